// File: rtl/wb_regfile_pkg.sv
// -----------------------------------------------------------------------------
// misc_v_pkg
//   Shared constants and types for the MEM/WB write-back register file.
//   DATA_W     : datapath / register width
//   REG_ADDR_W : register index width
//   NUM_REGS   : number of architectural registers (2**REG_ADDR_W)
//   wb_src_e   : write-back source select, encoded to match IRegStore
// -----------------------------------------------------------------------------
package misc_v_pkg;

  localparam int DATA_W     = 16;
  localparam int REG_ADDR_W = 4;
  localparam int NUM_REGS   = 2 ** REG_ADDR_W;

  typedef enum logic {
    WB_SRC_ALU = 1'b0,
    WB_SRC_MEM = 1'b1
  } wb_src_e;

endpackage

// File: rtl/wb_regfile_reg_array.sv
// -----------------------------------------------------------------------------
// wb_regfile_reg_array
//   Register storage: one synchronous write port, two asynchronous read ports.
//   Contents clear asynchronously on reset; index 0 is hardwired to zero.
// Ports:
//   clk     in  rising-edge clock
//   rst_n   in  asynchronous active-low reset
//   we      in  write enable (writes to index 0 are ignored)
//   waddr   in  write index
//   wdata   in  write data
//   raddr1  in  read port 1 index      rdata1 out read port 1 data
//   raddr2  in  read port 2 index      rdata2 out read port 2 data
// -----------------------------------------------------------------------------
module wb_regfile_reg_array #(
  parameter int DATA_W     = misc_v_pkg::DATA_W,
  parameter int REG_ADDR_W = misc_v_pkg::REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [REG_ADDR_W-1:0] raddr1,
  input  logic [REG_ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0]     rdata1,
  output logic [DATA_W-1:0]     rdata2
);
  import misc_v_pkg::*;

  localparam int NREGS = 2 ** REG_ADDR_W;

  logic [DATA_W-1:0] mem_q [NREGS];
  logic [DATA_W-1:0] mem_d [NREGS];

  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      mem_d[i] = mem_q[i];
    end
    // Entry 0 is never written, so it keeps its reset value of zero.
    if (we && (waddr != '0)) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign rdata1 = (raddr1 == '0) ? '0 : mem_q[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : mem_q[raddr2];

endmodule

// File: rtl/wb_regfile.sv
// -----------------------------------------------------------------------------
// wb_regfile
//   Write-back end of the MEM/WB boundary: selects the write-back value,
//   commits it to a 2**REG_ADDR_W x DATA_W register file, serves two
//   combinational read ports and counts committed writes.
// Configuration:
//   WB_REGFILE_BYPASS_EN : when defined, a read port whose index matches the
//                          register being committed this cycle returns
//                          OWbData directly (same-cycle write-through).
// Ports:
//   CLK        in  rising-edge clock
//   Reset      in  asynchronous active-low reset
//   IValid     in  MEM/WB slot holds a real instruction
//   IRegWrite  in  instruction writes a destination register
//   IRegStore  in  1 = write back IStoreMem, 0 = IALUResult
//   IALUResult in  ALU result
//   IStoreMem  in  memory read data
//   IRd        in  destination field (only low REG_ADDR_W bits used)
//   IRs1Addr   in  read port 1 index   ORs1Data out read port 1 data
//   IRs2Addr   in  read port 2 index   ORs2Data out read port 2 data
//   OWbData    out selected write-back value (combinational)
//   OWbCount   out committed-write counter (wraps)
// -----------------------------------------------------------------------------
module wb_regfile #(
  parameter int DATA_W     = misc_v_pkg::DATA_W,
  parameter int REG_ADDR_W = misc_v_pkg::REG_ADDR_W,
  parameter int CNT_W      = 16
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic                  IValid,
  input  logic                  IRegWrite,
  input  logic                  IRegStore,
  input  logic [DATA_W-1:0]     IALUResult,
  input  logic [DATA_W-1:0]     IStoreMem,
  input  logic [15:0]           IRd,
  input  logic [REG_ADDR_W-1:0] IRs1Addr,
  input  logic [REG_ADDR_W-1:0] IRs2Addr,
  output logic [DATA_W-1:0]     ORs1Data,
  output logic [DATA_W-1:0]     ORs2Data,
  output logic [DATA_W-1:0]     OWbData,
  output logic [CNT_W-1:0]      OWbCount
);
  import misc_v_pkg::*;

  wb_src_e               wb_src;
  logic [REG_ADDR_W-1:0] rd;
  logic                  commit;
  logic [DATA_W-1:0]     arr_rs1;
  logic [DATA_W-1:0]     arr_rs2;
  logic [CNT_W-1:0]      count_q;
  logic [CNT_W-1:0]      count_d;

  // Upper destination bits alias onto the low index; they carry no meaning.
  logic unused_rd_hi;
  assign unused_rd_hi = ^IRd[15:REG_ADDR_W];

  assign rd     = IRd[REG_ADDR_W-1:0];
  assign wb_src = wb_src_e'(IRegStore);

  always_comb begin
    OWbData = IALUResult;
    if (wb_src == WB_SRC_MEM) begin
      OWbData = IStoreMem;
    end
  end

  // Writes to index 0 are discarded and must not count as commits.
  assign commit = Reset && IValid && IRegWrite && (rd != '0);

  wb_regfile_reg_array #(
    .DATA_W     (DATA_W),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_reg_array (
    .clk    (CLK),
    .rst_n  (Reset),
    .we     (commit),
    .waddr  (rd),
    .wdata  (OWbData),
    .raddr1 (IRs1Addr),
    .raddr2 (IRs2Addr),
    .rdata1 (arr_rs1),
    .rdata2 (arr_rs2)
  );

  always_comb begin
    count_d = count_q;
    if (commit) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign OWbCount = count_q;

`ifdef WB_REGFILE_BYPASS_EN
  // commit already excludes rd == 0, so index 0 can never be forwarded.
  always_comb begin
    ORs1Data = arr_rs1;
    ORs2Data = arr_rs2;
    if (commit && (IRs1Addr == rd)) begin
      ORs1Data = OWbData;
    end
    if (commit && (IRs2Addr == rd)) begin
      ORs2Data = OWbData;
    end
  end
`else
  assign ORs1Data = arr_rs1;
  assign ORs2Data = arr_rs2;
`endif

endmodule
